// File: rtl/flash_seq_ctrl.sv
// flash_seq_ctrl
//   Sequences one user flash request (read / page program / sector erase) into
//   the SPI command chain seen by the SPI driver: optional WREN, the main
//   command, then RDSR polling until WIP clears or the poll budget runs out.
//   Program bytes and read bytes are forwarded between user side and driver.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_user_*              request (cmd/addr/len/valid) and program byte
//   o_user_ready          high only while idle
//   o_user_wr_req         request for the next program byte
//   o_user_rd_data/valid  read bytes from the flash array
//   o_busy/o_done/o_error status and completion pulses
//   o_spi_op_*            instruction handed to the driver (valid/ready)
//   o_spi_write_*/read_len data-phase configuration for the driver
//   i_spi_*               driver ready, byte request, read byte strobe
module flash_seq_ctrl #(
    parameter int P_POLL_GAP   = 100,
    parameter int P_POLL_MAX   = 4096,
    parameter int P_POLL_CNT_W = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [1:0]  i_user_cmd,
    input  logic [23:0] i_user_addr,
    input  logic [8:0]  i_user_len,
    input  logic        i_user_valid,
    output logic        o_user_ready,
    input  logic [7:0]  i_user_wr_data,
    output logic        o_user_wr_req,
    output logic [7:0]  o_user_rd_data,
    output logic        o_user_rd_valid,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [31:0] o_spi_op_data,
    output logic [8:0]  o_spi_op_len,
    output logic [1:0]  o_spi_op_type,
    output logic        o_spi_op_valid,
    input  logic        i_spi_ready,
    output logic [7:0]  o_spi_write_data,
    output logic [8:0]  o_spi_write_len,
    output logic [8:0]  o_spi_read_len,
    input  logic        i_spi_write_req,
    input  logic [7:0]  i_spi_read_data,
    input  logic        i_spi_read_valid
);

    typedef enum logic [3:0] {
        S_IDLE, S_ERR, S_WREN, S_WREN_WAIT, S_CMD, S_CMD_WAIT,
        S_POLL_GAP, S_POLL, S_POLL_WAIT, S_DONE
    } state_t;

    localparam logic [1:0] CMD_READ  = 2'd0;
    localparam logic [1:0] CMD_PROG  = 2'd1;
    localparam logic [1:0] CMD_ERASE = 2'd2;
    localparam logic [1:0] CMD_RSVD  = 2'd3;

    localparam logic [P_POLL_CNT_W-1:0] GAP_LAST  = P_POLL_CNT_W'(P_POLL_GAP - 1);
    localparam logic [P_POLL_CNT_W-1:0] POLL_LAST = P_POLL_CNT_W'(P_POLL_MAX - 1);

    state_t                  state_q, state_d;
    logic [1:0]              cmd_q, cmd_d;
    logic [23:0]             addr_q, addr_d;
    logic [8:0]              len_q, len_d;
    logic                    first_q, first_d;    // first cycle of a _WAIT state
    logic [P_POLL_CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [P_POLL_CNT_W-1:0] poll_cnt_q, poll_cnt_d;
    logic                    wip_q, wip_d;
    logic                    wr_req_q;
    logic [7:0]              rd_data_q;
    logic                    rd_valid_q;

    logic [9:0] page_end;
    logic       reject;
    logic       handshake;
    logic       wait_done;
    logic       wip_now;
    logic       prog_data_phase;

    assign page_end  = {2'b00, i_user_addr[7:0]} + {1'b0, i_user_len};
    assign reject    = (i_user_cmd == CMD_RSVD)
                     | ((i_user_len == 9'd0) & (i_user_cmd != CMD_ERASE))
                     | ((i_user_cmd == CMD_PROG) & (page_end > 10'd256));
    assign handshake = o_spi_op_valid & i_spi_ready;
    // The driver's ready is still high from the handshake cycle, so it only
    // counts as completion from the second _WAIT cycle on.
    assign wait_done = i_spi_ready & ~first_q;
    // A status byte arriving in the completion cycle itself is honoured.
    assign wip_now   = i_spi_read_valid ? i_spi_read_data[0] : wip_q;
    assign prog_data_phase = (state_q == S_CMD_WAIT) & (cmd_q == CMD_PROG);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            cmd_q      <= CMD_READ;
            addr_q     <= '0;
            len_q      <= '0;
            first_q    <= 1'b0;
            gap_cnt_q  <= '0;
            poll_cnt_q <= '0;
            wip_q      <= 1'b0;
            wr_req_q   <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            first_q    <= first_d;
            gap_cnt_q  <= gap_cnt_d;
            poll_cnt_q <= poll_cnt_d;
            wip_q      <= wip_d;
            wr_req_q   <= i_spi_write_req & prog_data_phase;
            rd_valid_q <= i_spi_read_valid & (state_q == S_CMD_WAIT) & (cmd_q == CMD_READ);
            if (i_spi_read_valid & (state_q == S_CMD_WAIT) & (cmd_q == CMD_READ)) begin
                rd_data_q <= i_spi_read_data;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        len_d      = len_q;
        first_d    = 1'b0;
        gap_cnt_d  = gap_cnt_q;
        poll_cnt_d = poll_cnt_q;
        wip_d      = wip_q;
        case (state_q)
            S_IDLE: begin
                if (i_user_valid) begin
                    cmd_d      = i_user_cmd;
                    addr_d     = i_user_addr;
                    len_d      = i_user_len;
                    poll_cnt_d = '0;
                    wip_d      = 1'b0;
                    if (reject)                        state_d = S_ERR;
                    else if (i_user_cmd == CMD_READ)   state_d = S_CMD;
                    else                               state_d = S_WREN;
                end
            end
            S_WREN: begin
                if (handshake) begin
                    state_d = S_WREN_WAIT;
                    first_d = 1'b1;
                end
            end
            S_WREN_WAIT: begin
                if (wait_done) state_d = S_CMD;
            end
            S_CMD: begin
                if (handshake) begin
                    state_d = S_CMD_WAIT;
                    first_d = 1'b1;
                end
            end
            S_CMD_WAIT: begin
                if (wait_done) begin
                    if (cmd_q == CMD_READ) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_POLL_GAP;
                        gap_cnt_d = '0;
                    end
                end
            end
            S_POLL_GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = S_POLL;
                else                       gap_cnt_d = gap_cnt_q + 1'b1;
            end
            S_POLL: begin
                if (handshake) begin
                    state_d = S_POLL_WAIT;
                    first_d = 1'b1;
                    // Assume still busy unless the driver returns a status byte.
                    wip_d   = 1'b1;
                end
            end
            S_POLL_WAIT: begin
                if (i_spi_read_valid) wip_d = i_spi_read_data[0];
                if (wait_done) begin
                    if (!wip_now) begin
                        state_d = S_DONE;
                    end else if (poll_cnt_q == POLL_LAST) begin
                        state_d = S_ERR;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 1'b1;
                        gap_cnt_d  = '0;
                        state_d    = S_POLL_GAP;
                    end
                end
            end
            S_ERR, S_DONE: state_d = S_IDLE;
            default:       state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_spi_op_valid = (state_q == S_WREN) | (state_q == S_CMD) | (state_q == S_POLL);
        o_spi_op_data  = '0;
        o_spi_op_len   = 9'd8;
        o_spi_op_type  = 2'd0;
        case (state_q)
            S_WREN, S_WREN_WAIT: o_spi_op_data = {8'h06, 24'h0};
            S_CMD, S_CMD_WAIT: begin
                o_spi_op_len = 9'd32;
                case (cmd_q)
                    CMD_READ: begin
                        o_spi_op_data = {8'h03, addr_q};
                        o_spi_op_type = 2'd1;
                    end
                    CMD_PROG: begin
                        o_spi_op_data = {8'h02, addr_q};
                        o_spi_op_type = 2'd2;
                    end
                    default:  o_spi_op_data = {8'h20, addr_q};
                endcase
            end
            S_POLL, S_POLL_WAIT: begin
                o_spi_op_data = {8'h05, 24'h0};
                o_spi_op_type = 2'd1;
            end
            default: ;
        endcase
    end

    assign o_user_ready     = (state_q == S_IDLE);
    assign o_busy           = (state_q != S_IDLE);
    assign o_done           = (state_q == S_DONE);
    assign o_error          = (state_q == S_ERR);
    assign o_user_wr_req    = wr_req_q;
    assign o_user_rd_data   = rd_data_q;
    assign o_user_rd_valid  = rd_valid_q;
    assign o_spi_write_data = prog_data_phase ? i_user_wr_data : 8'h00;
    assign o_spi_write_len  = (o_busy & (cmd_q == CMD_PROG)) ? len_q : 9'd0;
    // Status polls read one byte; otherwise only a user read has a read phase.
    assign o_spi_read_len   = ((state_q == S_POLL) | (state_q == S_POLL_WAIT)) ? 9'd1 :
                              (o_busy & (cmd_q == CMD_READ)) ? len_q : 9'd0;

endmodule

// File: tb/tb_flash_seq_ctrl.sv
// Bench for flash_seq_ctrl: a behavioural SPI driver, a user-side byte source
// and a scoreboard of expected ops, bytes and outcomes built from the request
// rules at issue time.
module tb_flash_seq_ctrl;
    localparam int GAP  = 5;
    localparam int PMAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  user_cmd = '0;
    logic [23:0] user_addr = '0;
    logic [8:0]  user_len = '0;
    logic        user_valid = 1'b0;
    logic        user_ready;
    logic [7:0]  user_wr_data = '0;
    logic        user_wr_req;
    logic [7:0]  user_rd_data;
    logic        user_rd_valid;
    logic        busy, done, error;
    logic [31:0] op_data;
    logic [8:0]  op_len;
    logic [1:0]  op_type;
    logic        op_valid;
    logic        spi_ready = 1'b1;
    logic [7:0]  spi_write_data;
    logic [8:0]  spi_write_len, spi_read_len;
    logic        spi_write_req = 1'b0;
    logic [7:0]  spi_read_data = '0;
    logic        spi_read_valid = 1'b0;

    always #5 clk = ~clk;

    flash_seq_ctrl #(.P_POLL_GAP(GAP), .P_POLL_MAX(PMAX), .P_POLL_CNT_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_user_cmd(user_cmd), .i_user_addr(user_addr), .i_user_len(user_len),
        .i_user_valid(user_valid), .o_user_ready(user_ready),
        .i_user_wr_data(user_wr_data), .o_user_wr_req(user_wr_req),
        .o_user_rd_data(user_rd_data), .o_user_rd_valid(user_rd_valid),
        .o_busy(busy), .o_done(done), .o_error(error),
        .o_spi_op_data(op_data), .o_spi_op_len(op_len), .o_spi_op_type(op_type),
        .o_spi_op_valid(op_valid), .i_spi_ready(spi_ready),
        .o_spi_write_data(spi_write_data), .o_spi_write_len(spi_write_len),
        .o_spi_read_len(spi_read_len), .i_spi_write_req(spi_write_req),
        .i_spi_read_data(spi_read_data), .i_spi_read_valid(spi_read_valid)
    );

    typedef struct {
        logic [31:0] data;
        logic [8:0]  len;
        logic [1:0]  typ;
        logic [8:0]  wlen;
        logic [8:0]  rlen;
    } op_t;

    op_t        exp_ops[$];
    logic [7:0] rd_supply[$], rd_expect[$], wr_supply[$], wr_expect[$], st_supply[$];
    logic [1:0] exp_out[$];     // {done, error}
    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int force_stall = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL %s: event not expected", nm);
    endtask

    task automatic push_op(input logic [31:0] d, input logic [8:0] l, input logic [1:0] t,
                           input logic [8:0] wl, input logic [8:0] rl);
        op_t o;
        o.data = d; o.len = l; o.typ = t; o.wlen = wl; o.rlen = rl;
        exp_ops.push_back(o);
    endtask

    // Reference model: expected SPI ops, data bytes and outcome of one request.
    task automatic model(input logic [1:0] cmd, input logic [23:0] addr, input logic [8:0] len,
                         input logic [7:0] sts[$], input bit rnd, input logic [7:0] dbase);
        bit         rej, ok;
        int         npoll;
        logic [7:0] b, stb, opc;
        logic [8:0] wl;
        rej = (cmd == 2'd3) || (len == 9'd0 && cmd != 2'd2) ||
              (cmd == 2'd1 && (int'(addr[7:0]) + int'(len)) > 256);
        if (rej) begin
            exp_out.push_back(2'b01);
        end else if (cmd == 2'd0) begin
            for (int i = 0; i < int'(len); i++) begin
                b = rnd ? 8'($urandom) : 8'(dbase + 8'(i));
                rd_supply.push_back(b);
                rd_expect.push_back(b);
            end
            push_op({8'h03, addr}, 9'd32, 2'd1, 9'd0, len);
            exp_out.push_back(2'b10);
        end else begin
            wl  = (cmd == 2'd1) ? len : 9'd0;
            opc = (cmd == 2'd1) ? 8'h02 : 8'h20;
            push_op(32'h0600_0000, 9'd8, 2'd0, wl, 9'd0);
            push_op({opc, addr}, 9'd32, (cmd == 2'd1) ? 2'd2 : 2'd0, wl, 9'd0);
            for (int i = 0; i < int'(wl); i++) begin
                b = rnd ? 8'($urandom) : 8'(dbase + 8'(i));
                wr_supply.push_back(b);
                wr_expect.push_back(b);
            end
            npoll = 0;
            ok    = 1'b0;
            while (npoll < PMAX && !ok) begin
                stb = (npoll < sts.size()) ? sts[npoll] : 8'h01;
                st_supply.push_back(stb);
                push_op(32'h0500_0000, 9'd8, 2'd1, wl, 9'd1);
                npoll++;
                if (!stb[0]) ok = 1'b1;
            end
            exp_out.push_back(ok ? 2'b10 : 2'b01);
        end
    endtask

    task automatic issue(input logic [1:0] cmd, input logic [23:0] addr, input logic [8:0] len,
                         input bit junk);
        @(negedge clk);
        chk("ready_idle", user_ready, 1);
        user_cmd = cmd; user_addr = addr; user_len = len; user_valid = 1'b1;
        @(negedge clk);
        chk("ready_low_after_accept", user_ready, 0);
        chk("busy_after_accept", busy, 1);
        if (junk) begin
            user_cmd = 2'd0; user_len = 9'd1;
            repeat (6) @(negedge clk);
        end
        user_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_out.size() != 0 || !user_ready) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("request_finished_in_budget", (t < 3000) ? 1 : 0, 1);
        repeat (2) @(negedge clk);
        chk("ops_consumed", exp_ops.size(), 0);
        chk("rd_bytes_consumed", rd_expect.size(), 0);
        chk("wr_bytes_consumed", wr_expect.size(), 0);
    endtask

    task automatic do_req(input logic [1:0] cmd, input logic [23:0] addr, input logic [8:0] len,
                          input logic [7:0] sts[$], input bit junk, input bit rnd,
                          input logic [7:0] dbase);
        model(cmd, addr, len, sts, rnd, dbase);
        issue(cmd, addr, len, junk);
        wait_idle();
    endtask

    task automatic chk_reset_vals();
        chk("rst_user_ready", user_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_op_valid", op_valid, 0);
        chk("rst_op_len", op_len, 9'd8);
        chk("rst_op_data", op_data, 0);
        chk("rst_op_type", op_type, 0);
        chk("rst_wr_req", user_wr_req, 0);
        chk("rst_rd_valid", user_rd_valid, 0);
        chk("rst_rd_data", user_rd_data, 0);
        chk("rst_write_len", spi_write_len, 0);
        chk("rst_read_len", spi_read_len, 0);
        chk("rst_write_data", spi_write_data, 0);
    endtask

    // Behavioural SPI driver: stalls, handshakes, serves the data phase.
    initial begin : driver
        int   st, stall, left, wp, md, last_done;
        bit   bad;
        op_t  snap, e;
        st = 0; stall = 0; left = 0; wp = 0; md = 0; last_done = 0; bad = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                st = 0; spi_ready = 1'b1; spi_read_valid = 1'b0; spi_write_req = 1'b0;
            end else begin
                case (st)
                    0: if (op_valid) begin
                        snap.data = op_data; snap.len = op_len; snap.typ = op_type;
                        snap.wlen = spi_write_len; snap.rlen = spi_read_len;
                        bad = 1'b0;
                        if (snap.data[31:24] == 8'h05)
                            chk("poll_gap", ((cyc - last_done) > GAP) ? 1 : 0, 1);
                        stall = (force_stall >= 0) ? force_stall : $urandom_range(0, 3);
                        if (stall == 0) begin spi_ready = 1'b1; st = 2; end
                        else begin spi_ready = 1'b0; st = 1; end
                    end else begin
                        spi_ready = 1'b1;
                    end
                    1: begin
                        if (!op_valid || op_data !== snap.data || op_len !== snap.len ||
                            op_type !== snap.typ) bad = 1'b1;
                        stall--;
                        if (stall == 0) begin spi_ready = 1'b1; st = 2; end
                    end
                    2: begin
                        chk("op_valid_drops_after_handshake", op_valid, 0);
                        chk("op_stable_while_stalled", bad, 0);
                        if (exp_ops.size() == 0) begin
                            fail_now("unexpected_op");
                        end else begin
                            e = exp_ops.pop_front();
                            chk("op_data", snap.data, e.data);
                            chk("op_len", snap.len, e.len);
                            chk("op_type", snap.typ, e.typ);
                            chk("op_write_len", snap.wlen, e.wlen);
                            chk("op_read_len", snap.rlen, e.rlen);
                        end
                        // Ready may linger one cycle; the sequencer must ignore it.
                        spi_ready = 1'($urandom_range(0, 1));
                        wp = 0;
                        if (snap.data[31:24] == 8'h05) begin md = 1; left = 1; end
                        else if (snap.typ == 2'd1) begin md = 2; left = int'(snap.rlen); end
                        else if (snap.typ == 2'd2) begin md = 3; left = int'(snap.wlen); end
                        else begin md = 0; left = 0; end
                        st = 3;
                    end
                    default: begin
                        spi_ready = 1'b0;
                        if (md == 1 || md == 2) begin
                            if (spi_read_valid) spi_read_valid = 1'b0;
                            else if (left > 0) begin
                                spi_read_valid = 1'b1;
                                if (md == 1) spi_read_data = (st_supply.size() != 0) ? st_supply.pop_front() : 8'h01;
                                else         spi_read_data = (rd_supply.size() != 0) ? rd_supply.pop_front() : 8'h00;
                                left--;
                            end else begin
                                spi_ready = 1'b1; st = 0; last_done = cyc;
                            end
                        end else if (md == 3) begin
                            if (wp == 0) begin
                                if (left == 0) begin spi_ready = 1'b1; st = 0; last_done = cyc; end
                                else begin spi_write_req = 1'b1; wp = 1; end
                            end else if (wp == 1) begin
                                spi_write_req = 1'b0; wp = 2;
                            end else begin
                                if (wr_expect.size() == 0) fail_now("unexpected_wr_byte");
                                else chk("wr_byte_to_driver", spi_write_data, wr_expect.pop_front());
                                left--; wp = 0;
                            end
                        end else begin
                            spi_ready = 1'b1; st = 0; last_done = cyc;
                        end
                    end
                endcase
            end
        end
    end

    // User-side program byte source: answers the cycle after each request.
    initial begin : user_src
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && user_wr_req)
                user_wr_data = (wr_supply.size() != 0) ? wr_supply.pop_front() : 8'h00;
        end
    end

    // Monitor: read bytes and completion pulses against the scoreboard.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (user_rd_valid) begin
                    if (rd_expect.size() == 0) fail_now("unexpected_user_rd_valid");
                    else chk("user_rd_byte", user_rd_data, rd_expect.pop_front());
                end
                if (done || error) begin
                    if (exp_out.size() == 0) fail_now("unexpected_done_or_error");
                    else chk("outcome_done_error", {done, error}, exp_out.pop_front());
                end
            end
        end
    end

    initial begin : main
        logic [7:0] sts[$];
        int t;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_reset_vals();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        sts = {};
        do_req(2'd0, 24'h001234, 9'd4, sts, 1'b0, 1'b0, 8'hA1);
        sts = {8'h03, 8'h03, 8'h00};
        do_req(2'd1, 24'h000010, 9'd16, sts, 1'b1, 1'b0, 8'h55);
        sts = {8'h01};
        do_req(2'd2, 24'h020000, 9'd0, sts, 1'b0, 1'b1, 8'h00);
        sts = {};
        do_req(2'd1, 24'h0000F0, 9'd32, sts, 1'b0, 1'b1, 8'h00);
        do_req(2'd3, 24'h000000, 9'd4, sts, 1'b0, 1'b1, 8'h00);
        do_req(2'd0, 24'h000000, 9'd0, sts, 1'b0, 1'b1, 8'h00);
        do_req(2'd1, 24'h0000F0, 9'd0, sts, 1'b0, 1'b1, 8'h00);
        sts = {8'h00};
        do_req(2'd1, 24'h0000F0, 9'd16, sts, 1'b0, 1'b1, 8'h00);
        do_req(2'd2, 24'h7FF000, 9'd0, sts, 1'b0, 1'b1, 8'h00);

        force_stall = 20;
        sts = {};
        do_req(2'd0, 24'h00ABCD, 9'd2, sts, 1'b0, 1'b1, 8'h00);
        force_stall = -1;

        // Reset in the middle of a page program data phase.
        sts = {8'h00};
        model(2'd1, 24'h000100, 9'd16, sts, 1'b0, 8'h10);
        issue(2'd1, 24'h000100, 9'd16, 1'b0);
        t = 0;
        while (wr_expect.size() > 12 && t < 2000) begin @(negedge clk); t++; end
        chk("pp_data_phase_reached", (t < 2000) ? 1 : 0, 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals();
        exp_ops.delete(); rd_supply.delete(); rd_expect.delete();
        wr_supply.delete(); wr_expect.delete(); st_supply.delete(); exp_out.delete();
        repeat (2) @(negedge clk);
        chk("rst_held_no_op_valid", op_valid, 0);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_resume_after_reset", busy, 0);
        sts = {};
        do_req(2'd0, 24'h000400, 9'd3, sts, 1'b0, 1'b1, 8'h00);

        for (int k = 0; k < 30; k++) begin
            int r;
            logic [1:0]  c;
            logic [23:0] a;
            logic [8:0]  l;
            r = $urandom_range(0, 9);
            c = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            a = 24'($urandom);
            if (c == 2'd1) a[7:0] = 8'($urandom_range(200, 255));
            l = (c == 2'd0) ? 9'($urandom_range(0, 10)) :
                (c == 2'd1) ? 9'($urandom_range(0, 60)) : 9'($urandom_range(0, 511));
            sts = {};
            for (int j = 0; j < int'($urandom_range(0, 5)); j++)
                sts.push_back({7'($urandom), 1'($urandom_range(0, 2) != 0)});
            do_req(c, a, l, sts, 1'b0, 1'b1, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/flash_seq_ctrl.md
Name: flash_seq_ctrl

Overview:
- Command sequencer between the user/flash-access logic and the SPI driver (spi_drive).
- Turns one user request (read, page program, sector erase) into the full SPI flash command chain: WREN, the main command, then status polling until WIP clears.
- Owns the driver's op handshake.
- Forwards program data and read data between the user side and the driver.

Parameters:
P_POLL_GAP, 100, idle clocks between consecutive RDSR polls (min 1)
P_POLL_MAX, 4096, max RDSR polls before timeout error (min 1)
P_POLL_CNT_W, 16, width of poll and gap counters

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_user_cmd  in  2  0=read 1=page program 2=sector erase 3=reserved
i_user_addr  in  24  flash byte address
i_user_len  in  9  data bytes 1..256 (read/program; ignored for erase)
i_user_valid  in  1  request valid
o_user_ready  out  1  high only in IDLE
i_user_wr_data  in  8  program byte, sampled on cycle after o_user_wr_req
o_user_wr_req  out  1  program byte request
o_user_rd_data  out  8  read byte
o_user_rd_valid  out  1  read byte strobe
o_busy  out  1  high outside IDLE
o_done  out  1  1-cycle pulse, request completed OK
o_error  out  1  1-cycle pulse, request rejected or poll timeout
o_spi_op_data  out  32  instruction left-aligned {opcode, addr}
o_spi_op_len  out  9  instruction length in bits (8 or 32)
o_spi_op_type  out  2  0=instruction only 1=read 2=write
o_spi_op_valid  out  1  op request to driver
i_spi_ready  in  1  driver ready
o_spi_write_data  out  8  program byte to driver
o_spi_write_len  out  9  program length in bytes
o_spi_read_len  out  9  read length in bytes
i_spi_write_req  in  1  driver requests next byte
i_spi_read_data  in  8  driver read byte
i_spi_read_valid  in  1  driver read strobe

Behaviour:
- Reset (async, i_rst_n=0):
  - State IDLE.
  - Outputs 0, except o_user_ready=1 and o_spi_op_len=9'd8.
  - o_spi_op_valid drops immediately, including mid-operation.
  - No resume after reset is released.
- Request accept: i_user_valid & o_user_ready. Latch cmd, addr, len; o_user_ready falls next cycle.
- Rejection: cmd=3, or len=0 with cmd 0/1, or program with addr[7:0]+len>256 (page cross).
  - ERR for 1 cycle, o_error pulse, back to IDLE.
  - No SPI op is issued.
- State sequences:
  - Read: CMD(0x03, len 32, type 1, read_len=len) -> CMD_WAIT -> DONE.
  - Program: WREN(0x06, len 8, type 0) -> WREN_WAIT -> CMD(0x02, len 32, type 2, write_len=len) -> CMD_WAIT -> POLL_GAP -> POLL -> POLL_WAIT -> DONE.
  - Erase: same as program, main command 0x20 (len 32, type 0).
  - o_spi_op_data={opcode, addr}; instructions without address carry {opcode, 24'h0}.
- Driver handshake:
  - o_spi_op_valid asserted on entry to WREN/CMD/POLL. Held, with payload stable, until valid & i_spi_ready; then moves to the matching _WAIT state.
  - In _WAIT, i_spi_ready is ignored on the first cycle after the handshake. Completion is i_spi_ready=1 on any later cycle.
- Polling:
  - POLL issues RDSR {0x05, 24'h0}, len 8, type 1, read_len=1.
  - The byte with i_spi_read_valid is captured internally, not forwarded.
  - On completion: if captured bit0 (WIP)=0 -> DONE.
  - Else increment poll count; if count==P_POLL_MAX -> ERR (o_error); else POLL_GAP for P_POLL_GAP clocks, then POLL.
  - The first poll is also preceded by POLL_GAP.
- Data forwarding:
  - o_user_wr_req = i_spi_write_req gated by program CMD_WAIT, registered 1 cycle.
  - o_spi_write_data = i_user_wr_data, combinational.
  - o_user_rd_data/o_user_rd_valid = i_spi_read_data/i_spi_read_valid, registered 1 cycle, only in read CMD_WAIT. Status reads never appear on the user side.
- DONE: 1 cycle, o_done pulse, then IDLE. o_busy=0 only in IDLE.
- Output stability: o_spi_write_len and o_spi_read_len hold the latched length throughout the request. Unused length is 0.
- i_user_valid while busy: ignored (ready=0).
- i_spi_read_valid/i_spi_write_req outside the expected states: dropped.

Test Plan:
- Read addr 0x001234, len 4; driver returns 0xA1..0xA4 -> one op {0x03,0x001234}, len 32, type 1, read_len 4; four o_user_rd_valid with A1..A4; o_done once.
- Program addr 0x000010, len 16, data 0x55 incrementing -> WREN (0x06000000, len 8), then PP {0x02,0x000010}, write_len 16. 16 o_user_wr_req; driver sees 0x55..0x64. Status 0x03, 0x03, 0x00 -> exactly 3 RDSR ops, gaps ≥P_POLL_GAP, o_done; no rd_valid to user.
- Erase addr 0x020000 with status stuck 0x01, P_POLL_MAX=4 -> WREN, SE {0x20,0x020000}, 4 RDSR, o_error pulse, return to IDLE, o_done never.
- Rejects: program addr 0x0000F0 len 32; cmd=3; read len 0 -> o_error each, o_spi_op_valid never asserts.
- Driver holds i_spi_ready=0 for 20 cycles with valid pending -> op_data/len/type stable, valid held, single handshake.
- Assert i_rst_n=0 during PP data phase -> all outputs at reset values immediately. After release, o_user_ready=1 and a new read completes normally.
